ni_be_bus_master: RTL and testbench
===================================

// Module: ni_be_bus_master
// PURPOSE
//  Bus initiator for the NI BE channel register space; drives the generic bus as master.
//  Converts cmd/rsp handshakes into single bus transactions, one outstanding at a time.
//  After reset it auto-reads the channel-0 info word and publishes NUM_BE_ENDPOINTS and ENABLE_DR.
//  Sits between a local controller (CPU shim or debug unit) and the NI BE channel block.
// PARAMETERS
//  MAX_CHANNEL     2    highest legal channel index (channel 0 = info, 1..MAX_CHANNEL = BE endpoints)
//  TIMEOUT_CYCLES  64   bus cycles without ack/err before abort; must be >=2, counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk_bus       in   1   bus clock; sole clock
//  rst_bus_n     in   1   reset, asynchronous assert, active-low
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   command accepted when valid&ready
//  cmd_we        in   1   1 = write, 0 = read
//  cmd_channel   in   7   channel index -> bus_addr[19:13]
//  cmd_offset    in   13  register offset -> bus_addr[12:0]
//  cmd_wdata     in   32  write data
//  rsp_valid     out  1   response available
//  rsp_ready     in   1   response consumed when valid&ready
//  rsp_data      out  32  read data (0 for writes and errors)
//  rsp_err       out  1   bus_err, timeout or illegal channel
//  rsp_timeout   out  1   abort by timeout (implies rsp_err)
//  bus_addr      out  32  {12'b0, channel, offset}
//  bus_we        out  1   write enable
//  bus_en        out  1   transaction strobe, held until termination
//  bus_data_out  out  32  write data to slave
//  bus_data_in   in   32  read data from slave, valid with bus_ack
//  bus_ack       in   1   slave ack (may be combinational in the bus_en cycle)
//  bus_err       in   1   slave error
//  info_valid    out  1   info word captured successfully
//  info_err      out  1   info read failed (err/timeout)
//  info_num_ep   out  31  info word [30:0]
//  info_dr       out  1   info word [31]
// BEHAVIOUR
//  Reset: all outputs 0; FSM = INIT; timeout counter 0; all bus_* outputs registered.
//  INIT: bus_en=1, bus_we=0, bus_addr=0 from the first cycle after reset release; cmd_ready=0.
//   Ack: latch info_num_ep/info_dr, info_valid=1 -> IDLE. Err or timeout: info_err=1 -> IDLE.
//   info_* are never updated again until the next reset.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register the command:
//   cmd_channel>MAX_CHANNEL -> no bus access; next cycle rsp_valid=1, rsp_err=1 -> RSP.
//   Otherwise -> REQ; bus_en=1 with addr/we/data on the next cycle.
//  REQ: bus_en, bus_addr, bus_we, bus_data_out stable until termination.
//   Termination = bus_ack | bus_err | (cnt==TIMEOUT_CYCLES-1); cnt increments each REQ cycle.
//   Next cycle: bus_en=0, cnt=0, rsp_valid=1 -> RSP. rsp_data=bus_data_in on read-ack, else 0.
//   ack and err in the same cycle: err wins (rsp_err=1, rsp_data=0).
//   ack on the timeout cycle: ack wins (rsp_timeout=0).
//  RSP: rsp_* held stable while rsp_ready=0; on rsp_ready -> IDLE, rsp_valid=0 next cycle.
//   cmd_ready=0 in RSP (strictly one outstanding transaction).
//  Latency: accept -> bus_en is 1 cycle; ack at cycle k of bus_en -> rsp_valid at k+1.
//   Back-to-back throughput with a combinational-ack slave: 1 command per 3 cycles.
//  Reset mid-transaction: bus_en drops asynchronously, pending response discarded, FSM re-enters INIT.
// TESTING
//  Reset release, slave acks addr 0 with 32'h8000_0002 -> info_valid=1, info_dr=1, info_num_ep=2, bus_en low 1 cycle later.
//  Read ch1 off 0x4, slave acks data 32'hCAFE_0001 in the 3rd en cycle -> bus_addr=32'h0000_2004, rsp_data=32'hCAFE_0001, rsp_err=0.
//  Write ch2 data 32'h1234 with ack and err asserted together -> bus_we=1, bus_data_out=32'h1234, rsp_err=1, rsp_timeout=0, rsp_data=0.
//  Read ch1 with no ack, TIMEOUT_CYCLES=64 -> bus_en high exactly 64 cycles, then rsp_err=1, rsp_timeout=1.
//  cmd_channel=5 with MAX_CHANNEL=2 -> bus_en never asserted, rsp_err=1 the cycle after accept.
//  rsp_ready held 0 for 10 cycles, then rst_bus_n pulsed during REQ -> rsp stable; after reset, rsp_valid=0 and INIT read reissued.

Source files
------------

// File: rtl/ni_be_bus_master.sv
// Bus initiator for the NI BE channel register space.
// Turns cmd/rsp handshakes into single bus transactions, one outstanding at a time.
// After reset it reads the channel-0 info word and publishes the endpoint count and DR enable.
//
// state | meaning
// INIT  | reading info word at address 0 (bus_en high from the first cycle after reset)
// IDLE  | waiting for a command, cmd_ready high
// REQ   | bus transaction in flight, waiting for ack/err/timeout
// RSP   | response presented, waiting for rsp_ready
module ni_be_bus_master #(
  parameter int MAX_CHANNEL    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_bus,
  input  logic        rst_bus_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [6:0]  cmd_channel,
  input  logic [12:0] cmd_offset,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic        bus_en,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        info_valid,
  output logic        info_err,
  output logic [30:0] info_num_ep,
  output logic        info_dr
);

  localparam int         CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] MAX_CH = 7'(MAX_CHANNEL);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ, S_RSP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             legal;
  logic             tc;
  logic             term;
  logic             term_err;
  logic             term_tmo;

  assign accept   = cmd_valid & cmd_ready;
  assign legal    = (cmd_channel <= MAX_CH);
  assign tc       = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // bus_en is only high in INIT/REQ, so it qualifies termination in both states
  assign term     = bus_en & (bus_ack | bus_err | tc);
  // err beats ack; ack on the last timeout cycle still counts as success
  assign term_err = bus_err | ~bus_ack;
  assign term_tmo = ~bus_ack & ~bus_err;

  // State register
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) state <= S_INIT;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (term)      state_nxt = S_IDLE;
      S_IDLE: if (accept)    state_nxt = legal ? S_REQ : S_RSP;
      S_REQ:  if (term)      state_nxt = S_RSP;
      S_RSP:  if (rsp_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_INIT;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RSP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Timeout counter: counts bus_en cycles, cleared on termination
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n)         cnt <= '0;
    else if (term || !bus_en) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

  // Registered bus side; command is captured straight into the bus registers
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      bus_en       <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_data_out <= '0;
    end else begin
      bus_en <= (state_nxt == S_INIT) || (state_nxt == S_REQ);
      if (accept && legal) begin
        bus_we       <= cmd_we;
        bus_addr     <= {12'b0, cmd_channel, cmd_offset};
        bus_data_out <= cmd_wdata;
      end
    end
  end

  // Response capture at termination or illegal-channel accept
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (accept && !legal) begin
      rsp_data    <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b0;
    end else if (state == S_REQ && term) begin
      rsp_err     <= term_err;
      rsp_timeout <= term_tmo;
      rsp_data    <= (!bus_we && bus_ack && !bus_err) ? bus_data_in : '0;
    end
  end

  // Info word capture, once per reset
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      info_valid  <= 1'b0;
      info_err    <= 1'b0;
      info_num_ep <= '0;
      info_dr     <= 1'b0;
    end else if (state == S_INIT && term) begin
      if (term_err) begin
        info_err <= 1'b1;
      end else begin
        info_valid  <= 1'b1;
        info_num_ep <= bus_data_in[30:0];
        info_dr     <= bus_data_in[31];
      end
    end
  end

endmodule

// File: tb/tb_ni_be_bus_master.sv
module tb_ni_be_bus_master;

  localparam int MAX_CH = 2;
  localparam int TMO    = 64;

  logic        clk_bus = 1'b0;
  logic        rst_bus_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [6:0]  cmd_channel;
  logic [12:0] cmd_offset;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_timeout;
  logic [31:0] bus_addr;
  logic        bus_we, bus_en;
  logic [31:0] bus_data_out, bus_data_in;
  logic        bus_ack, bus_err;
  logic        info_valid, info_err;
  logic [30:0] info_num_ep;
  logic        info_dr;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ni_be_bus_master #(.MAX_CHANNEL(MAX_CH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_bus(clk_bus), .rst_bus_n(rst_bus_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_channel(cmd_channel), .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .info_valid(info_valid), .info_err(info_err),
    .info_num_ep(info_num_ep), .info_dr(info_dr)
  );

  always #5 clk_bus = ~clk_bus;

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as slave; ack_cyc = en cycle at which ack/err are driven (0 = never)
  task automatic run_txn(input string tag, input logic we, input logic [6:0] ch,
                         input logic [12:0] off, input logic [31:0] wd,
                         input int ack_cyc, input logic do_ack, input logic do_err,
                         input logic [31:0] din, input int hold);
    exp_t        e, got;
    int          n, w, exp_en;
    logic        legal;
    logic [31:0] exp_addr;
    legal    = (ch <= 7'(MAX_CH));
    exp_addr = {12'b0, ch, off};
    e.err    = !legal || do_err || (ack_cyc == 0);
    e.tmo    = legal && !do_err && (ack_cyc == 0);
    e.data   = (legal && !we && ack_cyc != 0 && do_ack && !do_err) ? din : 32'h0;
    exp_en   = !legal ? 0 : (ack_cyc == 0 ? TMO : ack_cyc);

    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin @(negedge clk_bus); w++; end
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_we = we; cmd_channel = ch; cmd_offset = off; cmd_wdata = wd;
    sb.push_back(e);
    @(posedge clk_bus); @(negedge clk_bus);
    cmd_valid = 1'b0;

    n = 0;
    while (bus_en === 1'b1 && n < 200) begin
      n++;
      chk({tag, "_addr"}, bus_addr, exp_addr);
      chk({tag, "_we"}, {31'b0, bus_we}, {31'b0, we});
      if (we) chk({tag, "_wdata"}, bus_data_out, wd);
      if (n == ack_cyc) begin bus_ack = do_ack; bus_err = do_err; bus_data_in = din; end
      @(posedge clk_bus); @(negedge clk_bus);
      bus_ack = 1'b0; bus_err = 1'b0; bus_data_in = 32'h0;
    end
    chk({tag, "_en_cycles"}, 32'(n), 32'(exp_en));
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h1);
    chk({tag, "_cmd_ready_rsp"}, {31'b0, cmd_ready}, 32'h0);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk_bus); @(negedge clk_bus);
      chk({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
      chk({tag, "_hold_data"}, rsp_data, e.data);
      chk({tag, "_hold_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    end

    rsp_ready = 1'b1;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'h1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "_rsp_data"}, rsp_data, got.data);
      chk({tag, "_rsp_err"}, {31'b0, rsp_err}, {31'b0, got.err});
      chk({tag, "_rsp_timeout"}, {31'b0, rsp_timeout}, {31'b0, got.tmo});
    end
    @(posedge clk_bus); @(negedge clk_bus);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
  endtask

  initial begin
    rst_bus_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_channel = '0;
    cmd_offset = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    bus_data_in = '0; bus_ack = 1'b0; bus_err = 1'b0;

    repeat (3) @(negedge clk_bus);
    chk("rst_bus_en", {31'b0, bus_en}, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_info_valid", {31'b0, info_valid}, 32'h0);

    // Info read: slave acks on the first en cycle
    rst_bus_n = 1'b1;
    @(posedge clk_bus); @(negedge clk_bus);
    chk("init_en", {31'b0, bus_en}, 32'h1);
    chk("init_addr", bus_addr, 32'h0);
    chk("init_we", {31'b0, bus_we}, 32'h0);
    chk("init_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    bus_ack = 1'b1; bus_data_in = 32'h8000_0002;
    @(posedge clk_bus); @(negedge clk_bus);
    bus_ack = 1'b0; bus_data_in = '0;
    chk("info_valid", {31'b0, info_valid}, 32'h1);
    chk("info_err", {31'b0, info_err}, 32'h0);
    chk("info_dr", {31'b0, info_dr}, 32'h1);
    chk("info_num_ep", {1'b0, info_num_ep}, 32'h2);
    chk("init_en_drop", {31'b0, bus_en}, 32'h0);

    run_txn("rd_ch1", 1'b0, 7'd1, 13'h004, 32'h0, 3, 1'b1, 1'b0, 32'hCAFE_0001, 0);
    run_txn("wr_ch2_ackerr", 1'b1, 7'd2, 13'h010, 32'h1234, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 0);
    run_txn("wr_ch1_ack", 1'b1, 7'd1, 13'h1FFF, 32'hA5A5_5A5A, 2, 1'b1, 1'b0, 32'h0BAD_0BAD, 0);
    run_txn("rd_timeout", 1'b0, 7'd1, 13'h008, 32'h0, 0, 1'b0, 1'b0, 32'h0, 0);
    run_txn("rd_ack_at_tmo", 1'b0, 7'd2, 13'h00C, 32'h0, TMO, 1'b1, 1'b0, 32'h7777_0001, 0);
    run_txn("rd_err", 1'b0, 7'd0, 13'h000, 32'h0, 1, 1'b0, 1'b1, 32'h1111_1111, 0);
    run_txn("illegal_ch5", 1'b0, 7'd5, 13'h004, 32'h0, 0, 1'b0, 1'b0, 32'h0, 0);
    run_txn("rd_hold", 1'b0, 7'd2, 13'h0AA, 32'h0, 2, 1'b1, 1'b0, 32'h5555_AAAA, 10);

    // Reset in the middle of a transaction
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_channel = 7'd1; cmd_offset = 13'h020;
    @(posedge clk_bus); @(negedge clk_bus);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_bus);
    chk("midrst_en_before", {31'b0, bus_en}, 32'h1);
    rst_bus_n = 1'b0;
    #1;
    chk("midrst_en_async", {31'b0, bus_en}, 32'h0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    sb.delete();
    @(negedge clk_bus);
    rst_bus_n = 1'b1;
    @(posedge clk_bus); @(negedge clk_bus);
    chk("reinit_en", {31'b0, bus_en}, 32'h1);
    chk("reinit_addr", bus_addr, 32'h0);
    chk("reinit_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reinit_info_cleared", {31'b0, info_valid}, 32'h0);
    bus_err = 1'b1;
    @(posedge clk_bus); @(negedge clk_bus);
    bus_err = 1'b0;
    chk("reinit_info_err", {31'b0, info_err}, 32'h1);
    chk("reinit_info_valid", {31'b0, info_valid}, 32'h0);
    chk("reinit_en_drop", {31'b0, bus_en}, 32'h0);

    run_txn("rd_after_rst", 1'b0, 7'd2, 13'h004, 32'h0, 1, 1'b1, 1'b0, 32'h0DEF_0002, 0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
